// File: rtl/core_sequencer_if.sv
// Program-memory fetch handshake between core_sequencer (master) and
// instruction memory (slave).
interface core_sequencer_if #(
   parameter int unsigned PC_W = 5
);
   logic            fetch_req;
   logic [PC_W-1:0] fetch_addr;
   logic            fetch_ack;
   logic [15:0]     fetch_data;

   modport master (
      output fetch_req,
      output fetch_addr,
      input  fetch_ack,
      input  fetch_data
   );

   modport slave (
      input  fetch_req,
      input  fetch_addr,
      output fetch_ack,
      output fetch_data
   );
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit accumulator core.
// Owns the PC and instruction register and issues one-cycle execute strobes.
module core_sequencer #(
   parameter int unsigned     PC_W     = 5,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   core_sequencer_if.master     fetch,
   output logic [5:0]           instr_code,
   output logic [7:0]           imm,
   output logic                 load_en,
   output logic                 store_en,
   output logic                 acu_en,
   output logic                 r0_ce,
   output logic                 r1_ce,
   output logic                 r0_oe,
   output logic                 r1_oe,
   output logic                 busy,
   output logic                 halted,
   output logic                 sel_err,
   output logic [7:0]           retired
);

   localparam logic [5:0] OP_LD   = 6'h0A;
   localparam logic [5:0] OP_ST   = 6'h0B;
   localparam logic [5:0] OP_JMPF = 6'h0C;
   localparam logic [5:0] OP_JMPB = 6'h0D;
   localparam logic [5:0] OP_NOP  = 6'h3C;
   localparam logic [5:0] OP_HLT  = 6'h3F;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_HALT
   } state_t;

   state_t          state, state_next;
   logic [PC_W-1:0] pc, pc_next, imm_pc;
   logic [15:0]     ir;
   logic [5:0]      opcode;
   logic            sel_one;

   assign opcode  = ir[13:8];
   assign sel_one = ir[15] ^ ir[14];
   assign imm_pc  = PC_W'(ir[7:0]);

   // Opcode/immediate come straight from IR, which is only written in FETCH,
   // so they are stable registered values with no path from fetch_data.
   assign instr_code       = opcode;
   assign imm              = ir[7:0];
   assign fetch.fetch_addr = pc;

   always_comb begin
      unique case (opcode)
         OP_JMPF: pc_next = pc + imm_pc;
         OP_JMPB: pc_next = pc - imm_pc;
         default: pc_next = pc + PC_W'(1);
      endcase
   end

   always_comb begin
      state_next      = state;
      fetch.fetch_req = 1'b0;
      load_en         = 1'b0;
      store_en        = 1'b0;
      acu_en          = 1'b0;
      r0_ce           = 1'b0;
      r1_ce           = 1'b0;
      r0_oe           = 1'b0;
      r1_oe           = 1'b0;
      busy            = 1'b0;
      halted          = 1'b0;
      sel_err         = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (start) state_next = S_FETCH;
         end
         S_FETCH: begin
            fetch.fetch_req = 1'b1;
            busy            = 1'b1;
            if (fetch.fetch_ack) state_next = S_DECODE;
         end
         S_DECODE: begin
            busy       = 1'b1;
            r0_oe      = ir[14] & ~ir[15];
            r1_oe      = ir[15] & ~ir[14];
            state_next = (opcode == OP_HLT) ? S_HALT : S_EXEC;
         end
         S_EXEC: begin
            busy       = 1'b1;
            state_next = S_FETCH;
            unique case (opcode)
               OP_LD: load_en = 1'b1;
               OP_ST: begin
                  if (sel_one) begin
                     store_en = 1'b1;
                     r0_ce    = ir[14];
                     r1_ce    = ir[15];
                  end else begin
                     sel_err = 1'b1;
                  end
               end
               OP_JMPF, OP_JMPB, OP_NOP, OP_HLT: ;
               default: begin
                  acu_en = 1'b1;
                  r0_oe  = ir[14] & ~ir[15];
                  r1_oe  = ir[15] & ~ir[14];
               end
            endcase
         end
         S_HALT: halted = 1'b1;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         pc      <= RESET_PC;
         ir      <= '0;
         retired <= '0;
      end else begin
         state <= state_next;
         unique case (state)
            S_IDLE:  pc <= RESET_PC;
            S_FETCH: if (fetch.fetch_ack) ir <= fetch.fetch_data;
            S_DECODE: if (opcode == OP_HLT) retired <= retired + 8'd1;
            S_EXEC: begin
               pc      <= pc_next;
               retired <= retired + 8'd1;
            end
            default: ;
         endcase
      end
   end

endmodule
